// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encoding,
// trap cause codes and instruction constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {25'h0, OP_IMM};

    // Compressed/short encodings and the all-zero word are not executable here.
    function automatic logic is_illegal(input logic [31:0] ins);
        return (ins[1:0] != 2'b11) || (ins == 32'h0);
    endfunction

endpackage

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/execute sequencer: fetches into a held instruction register,
// gates the decoder write enable into one write-back cycle and traps on faults.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    input  logic             dec_rf_we,
    output logic             rf_we,
    output logic [31:0]      pc,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned    TO_W     = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(FETCH_TIMEOUT);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [TO_W-1:0]  tcnt_inc;

    assign tcnt_inc = tcnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        tcnt_d    = tcnt_q;
        imem_req  = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                tcnt_d   = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the limit cycle still counts as in time.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TO_LIMIT) begin
                        trap_d  = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                        state_d = ST_TRAP;
                    end
                end
            end
            ST_EXEC: begin
                if (is_illegal(instr_q)) begin
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we     = dec_rf_we;
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + CNT_W'(1);
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Randomised and directed bench for cpu_seq against an instruction-level model;
// a twin instance with a top-of-memory reset PC and 2-bit counter shares inputs.
module tb_cpu_seq;

    localparam int T = 16;
    localparam logic [31:0] W_PC_OFS = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        dec_rf_we = 1'b0;

    logic        imem_req, rf_we, busy, trap;
    logic [31:0] imem_addr, instr, pc;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    logic        req_w, rf_we_w, busy_w, trap_w;
    logic [31:0] addr_w, instr_w, pc_w;
    logic [1:0]  cause_w;
    logic [1:0]  instret_w;

    int checks = 0;
    int failures = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;

    cpu_seq #(.RESET_PC(32'h0), .FETCH_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .dec_rf_we(dec_rf_we), .rf_we(rf_we),
        .pc(pc), .busy(busy), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    cpu_seq #(.RESET_PC(W_PC_OFS), .FETCH_TIMEOUT(T), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr_w), .dec_rf_we(dec_rf_we), .rf_we(rf_we_w),
        .pc(pc_w), .busy(busy_w), .trap(trap_w), .trap_cause(cause_w),
        .instret(instret_w)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_pc_w"}, pc_w, m_pc + W_PC_OFS);
        chk({tag, "_instret"}, instret, m_instret);
        chk({tag, "_instret_w"}, {30'h0, instret_w}, {30'h0, m_instret[1:0]});
    endtask

    // Pulse reset, verify reset state, then release with run=1 and land in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        step();
        m_pc = 32'h0; m_instret = 32'h0; m_instr = 32'h0000_0013;
        chk_arch("rst");
        chk("rst_instr", instr, m_instr);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
        chk("rst_trap", {31'h0, trap}, 32'h0);
        chk("rst_cause", {30'h0, trap_cause}, 32'h0);
        rst = 1'b0;
        run = 1'b1;
        step();
    endtask

    // One instruction from FETCH. dly = WAIT cycle carrying rvalid (dly>T: never).
    task automatic do_instr(input logic [31:0] ins, input int dly, input logic we,
                            input logic drop, input logic early);
        int w;
        logic legal;
        legal = (ins[1:0] == 2'b11) && (ins != 32'h0);
        chk("fetch_req", {31'h0, imem_req}, 32'h1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_addr_w", addr_w, m_pc + W_PC_OFS);
        chk("fetch_req_w", {31'h0, req_w}, 32'h1);
        dec_rf_we = we;
        if (early) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~ins;
        end
        step();
        imem_rvalid = 1'b0;
        w = 1;
        while (w <= T) begin
            chk("wait_req", {31'h0, imem_req}, 32'h0);
            chk("wait_instr", instr, m_instr);
            chk("wait_busy", {31'h0, busy}, 32'h1);
            chk("wait_trap", {31'h0, trap}, 32'h0);
            if (drop) run = 1'b0;
            if (w == dly) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ins;
            end
            step();
            imem_rvalid = 1'b0;
            if (w == dly) w = T + 1;
            else w++;
        end
        if (dly > T) begin
            chk("to_trap", {31'h0, trap}, 32'h1);
            chk("to_trap_w", {31'h0, trap_w}, 32'h1);
            chk("to_cause", {30'h0, trap_cause}, 32'h2);
            chk("to_busy", {31'h0, busy}, 32'h0);
            chk_arch("to");
            return;
        end
        m_instr = ins;
        chk("exec_instr", instr, ins);
        chk("exec_instr_w", instr_w, ins);
        chk("exec_rf_we", {31'h0, rf_we}, 32'h0);
        chk_arch("exec");
        step();
        if (!legal) begin
            chk("ill_trap", {31'h0, trap}, 32'h1);
            chk("ill_cause", {30'h0, trap_cause}, 32'h1);
            chk("ill_cause_w", {30'h0, cause_w}, 32'h1);
            chk("ill_rf_we", {31'h0, rf_we}, 32'h0);
            chk("ill_busy", {31'h0, busy}, 32'h0);
            chk_arch("ill");
            return;
        end
        chk("wb_rf_we", {31'h0, rf_we}, {31'h0, we});
        chk("wb_rf_we_w", {31'h0, rf_we_w}, {31'h0, we});
        chk("wb_req", {31'h0, imem_req}, 32'h0);
        m_pc      = m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        step();
        dec_rf_we = 1'b0;
        chk_arch("post");
        chk("post_rf_we", {31'h0, rf_we}, 32'h0);
        chk("post_busy", {31'h0, busy}, {31'h0, run});
        chk("post_busy_w", {31'h0, busy_w}, {31'h0, run});
    endtask

    initial begin
        do_reset();

        // ADDI one cycle after request: 4-cycle cadence, pc=4, instret=1
        do_instr(32'h0050_0093, 1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_instr($urandom() | 32'h3, int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        // delayed response with a spurious rvalid during FETCH
        do_instr(32'h00a0_0113, 3, 1'b1, 1'b0, 1'b1);
        // response exactly on the timeout limit cycle must not trap
        do_instr(32'h0010_0193, T, 1'b1, 1'b0, 1'b0);

        // run dropped mid-fetch: instruction completes, then idle
        do_instr(32'h0020_0213, 2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_req", {31'h0, imem_req}, 32'h0);
            chk_arch("idle");
        end
        run = 1'b1;
        step();
        do_instr(32'h0030_0293, 1, 1'b0, 1'b0, 1'b0);

        // all-zero word traps as illegal; trap is sticky
        do_instr(32'h0, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ill_hold_trap", {31'h0, trap}, 32'h1);
            chk("ill_hold_req", {31'h0, imem_req}, 32'h0);
            chk("ill_hold_rf_we", {31'h0, rf_we}, 32'h0);
            chk_arch("ill_hold");
        end
        do_reset();

        // compressed-looking encoding
        do_instr(($urandom() & 32'hFFFF_FFFC) | 32'h1, 2, 1'b1, 1'b0, 1'b0);
        do_reset();

        // fetch timeout, then a late response is ignored
        do_instr(32'h0050_0093, 1000, 1'b1, 1'b0, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0070_0393;
        step();
        step();
        imem_rvalid = 1'b0;
        chk("late_trap", {31'h0, trap}, 32'h1);
        chk("late_cause", {30'h0, trap_cause}, 32'h2);
        chk("late_instr", instr, m_instr);
        chk("late_busy", {31'h0, busy}, 32'h0);
        chk_arch("late");
        do_reset();

        // a few instructions, then reset while waiting
        do_instr(32'h0050_0093, 1, 1'b1, 1'b0, 1'b0);
        do_instr(32'h0060_0313, 2, 1'b1, 1'b0, 1'b0);
        step();
        chk("midwait_busy", {31'h0, busy}, 32'h1);
        do_reset();
        do_instr(32'h0050_0093, 1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Multi-cycle sequencer for the single-issue RV32I core. Fetches each instruction from instruction memory and holds it stable for the combinational decoder. Gates the decoder's register-file write enable into a single write-back cycle, then advances the PC. Detects illegal encodings and fetch timeouts, and keeps a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, max cycles spent in WAIT before trapping (must be ≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
run  in  1  execution enable; sampled in IDLE and WB
imem_req  out  1  fetch request strobe, one cycle
imem_addr  out  32  fetch address (= pc)
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
instr  out  32  latched instruction to decoder
dec_rf_we  in  1  decoder's write-enable
rf_we  out  1  gated register-file write enable
pc  out  32  current PC
busy  out  1  high in any state except IDLE and TRAP
trap  out  1  sticky trap flag
trap_cause  out  2  01 illegal, 10 fetch timeout, 00 none
instret  out  CNT_W  retired-instruction count

Behaviour:
- One clock: clk. Reset is synchronous, active-high (rst). All state updates on posedge clk.
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), rf_we=0, imem_req=0, trap=0, trap_cause=00, instret=0, timeout counter=0. Reset overrides every state, including mid-fetch and TRAP.
- States: IDLE, FETCH, WAIT, EXEC, WB, TRAP.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: imem_req=1 and imem_addr=pc for exactly this cycle; clear timeout counter; -> WAIT. imem_rvalid during FETCH is ignored.
- WAIT: if imem_rvalid=1, instr<=imem_rdata -> EXEC. Otherwise increment the timeout counter. When the counter reaches FETCH_TIMEOUT -> TRAP with cause=10. rvalid on the same cycle as the limit wins: no trap.
- EXEC: instr held stable for decode/ALU. If instr[1:0]!=2'b11 or instr==32'h0 -> TRAP with cause=01, with no write and no PC change. Else -> WB.
- WB: rf_we=dec_rf_we for this single cycle. pc<=pc+4, wrapping modulo 2^32. instret<=instret+1, wrapping modulo 2^CNT_W. Then run=1 -> FETCH, else -> IDLE. Deasserting run mid-instruction always completes that instruction.
- TRAP: sticky until rst. rf_we=0, imem_req=0. pc holds the faulting instruction's address.
- rf_we is 0 in every state except WB. imem_req is 0 in every state except FETCH.
- Throughput: 4 cycles per instruction when rvalid arrives the cycle after FETCH; each extra WAIT cycle adds 1.
- imem_rvalid outside WAIT is ignored. Late responses after a timeout trap are ignored.

Decomposition:
- Shared package cpu_pkg holds: state encoding (3-bit localparams), trap cause codes, NOP constant 32'h0000_0013, opcode constants (OP_IMM=7'b0010011).
- No sub-module; the FSM, PC and counters live in one module.
- The top level instantiates cpu_seq alongside the existing decoder, feeding instr into it and taking dec_rf_we back.

Test Plan:
- Reset, run=1, memory returns ADDI 32'h0050_0093 one cycle after req -> imem_req pulses at cycles 0,4,8; rf_we high only in the 4th cycle; pc=0x4 after the first WB; instret=1.
- rvalid delayed 3 cycles -> instruction takes 7 cycles; instr changes only on the rvalid cycle; rvalid asserted during FETCH is ignored.
- rvalid never returns, FETCH_TIMEOUT=16 -> trap=1, trap_cause=10 after 16 WAIT cycles; pc unchanged; a later rvalid is ignored; rst clears trap.
- Fetch returns 32'h0000_0000 -> trap_cause=01; rf_we never asserts; instret unchanged.
- run dropped during WAIT -> current instruction completes through WB, then IDLE with busy=0; run reasserted -> fetch resumes at pc+4.
- RESET_PC=32'hFFFF_FFFC, one instruction -> pc wraps to 0; rst asserted mid-WAIT -> next cycle state=IDLE, pc=RESET_PC, instret=0.
